// File: rtl/param_universal_register.sv
// WIDTH-bit register with complementary output, reset-time preset select, clock enable,
// synchronous clear, load, shift/rotate both ways, up/down count and a one-cycle wrap flag.
module param_universal_register #(
  parameter int              WIDTH      = 8,
  parameter logic [WIDTH-1:0] CLEAR_VAL  = '0,
  parameter logic [WIDTH-1:0] PRESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             preset,
  input  logic             en,
  input  logic             clr,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             si_l,
  input  logic             si_r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             wrap
);

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_LOAD = 3'b001,
    M_SHL  = 3'b010,
    M_SHR  = 3'b011,
    M_ROL  = 3'b100,
    M_ROR  = 3'b101,
    M_UP   = 3'b110,
    M_DOWN = 3'b111
  } mode_t;

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt;
  logic             wrap_r;
  logic             wrap_nxt;
  logic             arst_pre;
  logic             arst_clr;

  // Reset split into two async controls so a preset change while rst is high
  // produces a fresh edge and re-selects the reset value immediately.
  assign arst_pre = rst & preset;
  assign arst_clr = rst & ~preset;

  always_comb begin
    q_nxt    = q_r;
    wrap_nxt = 1'b0;
    if (clr) begin
      q_nxt = CLEAR_VAL;
    end else if (en) begin
      case (mode_t'(mode))
        M_HOLD: q_nxt = q_r;
        M_LOAD: q_nxt = d;
        M_SHL:  q_nxt = {q_r[WIDTH-2:0], si_l};
        M_SHR:  q_nxt = {si_r, q_r[WIDTH-1:1]};
        M_ROL:  q_nxt = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
        M_ROR:  q_nxt = {q_r[0], q_r[WIDTH-1:1]};
        M_UP: begin
          q_nxt    = q_r + WIDTH'(1);
          wrap_nxt = (q_r == '1);
        end
        M_DOWN: begin
          q_nxt    = q_r - WIDTH'(1);
          wrap_nxt = (q_r == '0);
        end
        default: q_nxt = q_r;
      endcase
    end
  end

  always_ff @(posedge clk or posedge arst_pre or posedge arst_clr) begin
    if (arst_pre) begin
      q_r    <= PRESET_VAL;
      wrap_r <= 1'b0;
    end else if (arst_clr) begin
      q_r    <= CLEAR_VAL;
      wrap_r <= 1'b0;
    end else begin
      q_r    <= q_nxt;
      wrap_r <= wrap_nxt;
    end
  end

  assign q     = q_r;
  assign q_bar = ~q_r;
  assign wrap  = wrap_r;

endmodule

// File: tb/tb_param_universal_register.sv
// Self-checking bench for param_universal_register: directed vector table, async reset
// sequences, and random stimulus against an arithmetic reference model.
module tb_param_universal_register;
  localparam int W   = 8;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst, preset, en, clr, si_l, si_r;
  logic [2:0]   mode;
  logic [W-1:0] d;
  logic [W-1:0] q, q_bar;
  logic         wrap;

  int tests = 0;
  int fails = 0;

  param_universal_register #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .preset(preset), .en(en), .clr(clr), .mode(mode),
    .d(d), .si_l(si_l), .si_r(si_r), .q(q), .q_bar(q_bar), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         clr;
    logic         en;
    logic [2:0]   mode;
    logic [W-1:0] d;
    logic         sl;
    logic         sr;
    logic [W-1:0] eq;
    logic         ew;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int eq, input int ew);
    chk({nm, " q"}, 32'(q), 32'(eq));
    chk({nm, " q_bar"}, 32'(q_bar), 32'((MOD - 1) - eq));
    chk({nm, " wrap"}, 32'(wrap), 32'(ew));
  endtask

  task automatic drive(input logic c, input logic e, input logic [2:0] m,
                       input logic [W-1:0] dv, input logic sl, input logic sr);
    clr = c; en = e; mode = m; d = dv; si_l = sl; si_r = sr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model in plain integer arithmetic.
  function automatic void model(input int cq, input logic c, input logic e, input int m,
                                input int dv, input int sl, input int sr,
                                output int nq, output int nw);
    nq = cq;
    nw = 0;
    if (c) nq = 0;
    else if (e) begin
      case (m)
        1: nq = dv;
        2: nq = (cq * 2) % MOD + sl;
        3: nq = cq / 2 + sr * (MOD / 2);
        4: nq = (cq * 2) % MOD + cq / (MOD / 2);
        5: nq = cq / 2 + (cq % 2) * (MOD / 2);
        6: begin nq = (cq + 1) % MOD; nw = (cq == MOD - 1) ? 1 : 0; end
        7: begin nq = (cq + MOD - 1) % MOD; nw = (cq == 0) ? 1 : 0; end
        default: nq = cq;
      endcase
    end
  endfunction

  initial begin
    int mq, mw, nq, nw;
    logic rc, re;
    int rm, rd, rl, rr;

    tbl.push_back('{1'b0, 1'b1, 3'b001, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 3'b001, 8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'b010, 8'h00, 1'b1, 1'b0, 8'h4B, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'b011, 8'h00, 1'b0, 1'b0, 8'h25, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'b100, 8'h00, 1'b0, 1'b0, 8'h4A, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'b101, 8'h00, 1'b0, 1'b0, 8'h25, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'b001, 8'hFE, 1'b0, 1'b0, 8'hFE, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'b110, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'b110, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 3'b110, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'b001, 8'h01, 1'b0, 1'b0, 8'h01, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'b111, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'b111, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 3'b111, 8'h00, 1'b0, 1'b0, 8'hFE, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'b001, 8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 3'b110, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'b001, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'b000, 8'h5A, 1'b1, 1'b1, 8'h81, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'b011, 8'h00, 1'b0, 1'b1, 8'hC0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 3'b001, 8'h77, 1'b0, 1'b0, 8'h00, 1'b0});

    rst = 1'b1; preset = 1'b1;
    drive(1'b0, 1'b0, 3'b000, '0, 1'b0, 1'b0);
    #3;
    chk_all("reset preset=1", 8'hFF, 0);
    preset = 1'b0;
    #1;
    chk_all("reset preset->0", 8'h00, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_all("after release", 8'h00, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].clr, tbl[i].en, tbl[i].mode, tbl[i].d, tbl[i].sl, tbl[i].sr);
      tick();
      chk_all($sformatf("vec%0d", i), int'(tbl[i].eq), int'(tbl[i].ew));
    end

    // Async reset between edges while counting, then an edge during reset.
    drive(1'b0, 1'b1, 3'b001, 8'hFE, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b1, 3'b110, 8'h00, 1'b0, 1'b0); tick();
    chk_all("cnt ff", 8'hFF, 0);
    tick();
    chk_all("cnt wrap", 8'h00, 1);
    tick();
    #2;
    rst = 1'b1; preset = 1'b1;
    #1;
    chk_all("async rst mid", 8'hFF, 0);
    preset = 1'b0;
    #1;
    chk_all("async preset->0", 8'h00, 0);
    tick();
    chk_all("edge in reset", 8'h00, 0);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    tick();
    chk_all("post reset hold", 8'h00, 0);

    mq = 0; mw = 0;
    for (int i = 0; i < 400; i++) begin
      rc = ($urandom_range(0, 15) == 0);
      re = ($urandom_range(0, 3) != 0);
      rm = int'($urandom_range(0, 7));
      rd = int'($urandom_range(0, MOD - 1));
      rl = int'($urandom_range(0, 1));
      rr = int'($urandom_range(0, 1));
      // Bias toward the wrap boundaries now and then.
      if ($urandom_range(0, 9) == 0) rd = (rd % 2 == 0) ? 0 : MOD - 1;
      drive(rc, re, 3'(rm), W'(rd), rl[0], rr[0]);
      model(mq, rc, re, rm, rd, rl, rr, nq, nw);
      mq = nq; mw = nw;
      tick();
      chk_all($sformatf("rand%0d", i), mq, mw);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/param_universal_register.md
Name: param_universal_register

Overview:
- Parametrised next-generation storage element: a WIDTH-bit register generalising the single-bit D flip-flop with complementary output and reset-time preset selection.
- Adds clock enable, synchronous clear, parallel load, shift/rotate in both directions, up/down counting and a registered wrap flag.
- Serves as the common register/shift/counter primitive for lab datapaths and sequencers.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- CLEAR_VAL, 0, WIDTH-bit value loaded at reset when preset=0 and on synchronous clear.
- PRESET_VAL, all ones, WIDTH-bit value loaded at reset when preset=1.

Ports:
- clk  input  1  clock; rising edge active.
- rst  input  1  asynchronous active-high reset.
- preset  input  1  selects the reset value: 1 gives PRESET_VAL, 0 gives CLEAR_VAL. Sampled while rst is high.
- en  input  1  clock enable.
- clr  input  1  synchronous clear to CLEAR_VAL.
- mode  input  3  operation select.
- d  input  WIDTH  parallel load data.
- si_l  input  1  serial input entering at bit 0 on shift left.
- si_r  input  1  serial input entering at bit WIDTH-1 on shift right.
- q  output  WIDTH  register state.
- q_bar  output  WIDTH  bitwise complement of q.
- wrap  output  1  registered count wrap flag.

Behaviour:
- Clock and reset:
  - Single clock. Reset is asynchronous and active-high.
  - While rst=1: q = preset ? PRESET_VAL : CLEAR_VAL, independent of clk. q_bar = ~q. wrap = 0.
  - A change of preset while rst=1 updates q immediately.
  - Reset asserted mid-operation aborts the operation; no partial update survives.
- q_bar is always exactly ~q. It is either a registered complement or driven from q, but it must never differ from ~q, including during reset.
- Priority at each rising clk edge with rst=0: clr, then en, then mode.
- clr=1: q <= CLEAR_VAL and wrap <= 0, regardless of en.
- clr=0, en=0: q holds and wrap <= 0.
- clr=0, en=1, by mode:
  - 000 hold: q unchanged.
  - 001 load: q <= d.
  - 010 shift left: q <= {q[WIDTH-2:0], si_l}.
  - 011 shift right: q <= {si_r, q[WIDTH-1:1]}.
  - 100 rotate left: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 101 rotate right: q <= {q[0], q[WIDTH-1:1]}.
  - 110 count up: q <= q+1, modulo 2^WIDTH.
  - 111 count down: q <= q-1, modulo 2^WIDTH.
- wrap:
  - Set to 1 for exactly one cycle after an edge where mode=110 and q was all ones, or mode=111 and q was zero.
  - Otherwise wrap <= 0 on every edge, including non-counting modes.
- Arithmetic is unsigned, WIDTH bits; the carry out is discarded apart from wrap.
- Latency: one clk edge from inputs to q. No combinational path from inputs to q, q_bar or wrap.
- Simultaneous clr with any mode: clr wins. Reset release coinciding with a clk edge: that edge is ignored only if rst is still high when it arrives.
- X on mode while en=1 and clr=0 is a bench error. The RTL need not define q in that case.

Test Plan:
- rst=1 with preset=1, WIDTH=8 -> q=FF, q_bar=00, wrap=0. Toggle preset to 0 while still in reset -> q=00 with no clock edge.
- Release reset, en=1, mode=001, d=A5 -> q=A5 and q_bar=5A after one edge. Then en=0, mode=001, d=3C -> q stays A5.
- q=A5, mode=010, si_l=1 -> 4B. Then mode=011, si_r=0 -> 25. Then mode=100 -> 4A. Then mode=101 -> 25.
- Load FE, then mode=110 for 3 edges -> q goes FF, 00, 01. wrap=1 only in the cycle q=00.
- Load 01, then mode=111 for 2 edges -> q goes 00, FF. wrap=1 only in the cycle q=FF.
- Count up with clr=1 asserted on the same edge -> q=CLEAR_VAL and wrap=0. Then assert rst asynchronously between edges during counting -> q changes immediately to the preset-selected value.
